// File: rtl/shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL) moving up to STEP bit positions per clock over
// valid/ready handshakes. Define SHIFT_FLAGS_EN to add the registered carry/zero flags.
module shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic                       busy
`ifdef SHIFT_FLAGS_EN
    ,
    output logic                       carry,
    output logic                       zero
`endif
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned KW  = SHW + 1;

    localparam logic [1:0] OpSll = 2'd0;
    localparam logic [1:0] OpSrl = 2'd1;
    localparam logic [1:0] OpSra = 2'd2;
    localparam logic [1:0] OpRol = 2'd3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // One extra bit so STEP == WIDTH is representable.
    localparam logic [KW-1:0] StepW  = KW'(STEP);
    localparam logic [KW-1:0] WidthW = KW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic             out_valid_q, out_valid_d;

    logic [KW-1:0]    rem_ext;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFT_FLAGS_EN
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [SHW-1:0]   idx_l;
    logic [SHW-1:0]   idx_r;
    logic             step_carry;
`endif

    // Per-cycle step: k = min(STEP, remaining).
    always_comb begin
        rem_ext = {1'b0, rem_q};
        k       = (rem_ext < StepW) ? rem_ext : StepW;
        shifted = y_q;
        unique case (op_q)
            OpSll: shifted = y_q << k;
            OpSrl: shifted = y_q >> k;
            // y_q[WIDTH-1] keeps the original sign for the whole operation.
            OpSra: shifted = $unsigned($signed(y_q) >>> k);
            OpRol: shifted = (y_q << k) | (y_q >> (WidthW - k));
            default: shifted = y_q;
        endcase
    end

`ifdef SHIFT_FLAGS_EN
    // Last bit leaving the word on this step; over all steps this is the overall last bit out.
    always_comb begin
        idx_l      = SHW'(WidthW - k);
        idx_r      = SHW'(k - KW'(1));
        step_carry = 1'b0;
        unique case (op_q)
            OpSll: step_carry = y_q[idx_l];
            OpSrl: step_carry = y_q[idx_r];
            OpSra: step_carry = y_q[idx_r];
            OpRol: step_carry = shifted[0];
            default: step_carry = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        op_d        = op_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
`ifdef SHIFT_FLAGS_EN
        carry_d     = carry_q;
        zero_d      = zero_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_d   = a;
                    op_d  = op;
                    rem_d = shamt;
                    if (shamt == '0) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
`ifdef SHIFT_FLAGS_EN
                        carry_d     = 1'b0;
                        zero_d      = (a == '0);
`endif
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                y_d   = shifted;
                rem_d = rem_q - k[SHW-1:0];
                if (k == rem_ext) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
`ifdef SHIFT_FLAGS_EN
                    carry_d     = step_carry;
                    zero_d      = (shifted == '0);
`endif
                end
            end
            StDone: begin
                // Retire only; a pending request waits for the next IDLE cycle.
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            y_q         <= '0;
            op_q        <= OpSll;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SHIFT_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`endif

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: three configurations (8/1, 8/4, 32/1) checked against an arithmetic
// reference model; flag checks are compiled in when SHIFT_FLAGS_EN is defined.
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0;
    logic [31:0] a_in = '0;
    logic [4:0]  sh_in = '0;
    logic [1:0]  op_in = '0;
    logic        out_rdy = 1'b0;
    logic [7:0]  y0, y1;
    logic [31:0] y2;
    logic [2:0]  ov, ir, bs;
`ifdef SHIFT_FLAGS_EN
    logic [2:0]  cy, zr;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shift_unit #(.WIDTH(8), .STEP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_in[7:0]),
        .shamt(sh_in[2:0]), .op(op_in), .out_valid(ov[0]), .out_ready(out_rdy), .y(y0),
        .busy(bs[0])
`ifdef SHIFT_FLAGS_EN
        , .carry(cy[0]), .zero(zr[0])
`endif
    );

    shift_unit #(.WIDTH(8), .STEP(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_in[7:0]),
        .shamt(sh_in[2:0]), .op(op_in), .out_valid(ov[1]), .out_ready(out_rdy), .y(y1),
        .busy(bs[1])
`ifdef SHIFT_FLAGS_EN
        , .carry(cy[1]), .zero(zr[1])
`endif
    );

    shift_unit #(.WIDTH(32), .STEP(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_in),
        .shamt(sh_in), .op(op_in), .out_valid(ov[2]), .out_ready(out_rdy), .y(y2),
        .busy(bs[2])
`ifdef SHIFT_FLAGS_EN
        , .carry(cy[2]), .zero(zr[2])
`endif
    );

    function automatic int wid(input int sel);
        return (sel == 2) ? 32 : 8;
    endfunction

    function automatic int stp(input int sel);
        return (sel == 1) ? 4 : 1;
    endfunction

    // Reference: whole-word shift by s in one go, plus the last bit pushed out.
    function automatic void model(input int w, input longint unsigned av, input int s,
                                  input int o, output longint unsigned ey, output bit ec);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        av   = av & mask;
        ec   = 1'b0;
        case (o)
            0: begin
                ey = (av << s) & mask;
                if (s != 0) ec = ((av >> (w - s)) & 64'd1) != 0;
            end
            1: begin
                ey = av >> s;
                if (s != 0) ec = ((av >> (s - 1)) & 64'd1) != 0;
            end
            2: begin
                ey = av >> s;
                if (((av >> (w - 1)) & 64'd1) != 0) ey = ey | (mask & ~(mask >> s));
                if (s != 0) ec = ((av >> (s - 1)) & 64'd1) != 0;
            end
            default: begin
                ey = ((av << s) | (av >> (w - s))) & mask;
                if (s != 0) ec = (ey & 64'd1) != 0;
            end
        endcase
    endfunction

    task automatic sample(input int sel, output logic [31:0] yy, output logic o_v,
                          output logic o_r, output logic o_b, output logic o_c,
                          output logic o_z);
        case (sel)
            0: yy = {24'd0, y0};
            1: yy = {24'd0, y1};
            default: yy = y2;
        endcase
        o_v = ov[sel];
        o_r = ir[sel];
        o_b = bs[sel];
`ifdef SHIFT_FLAGS_EN
        o_c = cy[sel];
        o_z = zr[sel];
`else
        o_c = 1'b0;
        o_z = 1'b0;
`endif
    endtask

    // Accept one request and wait (bounded) for out_valid; leaves the unit in DONE.
    task automatic run_op(input int sel, input logic [31:0] av, input int s, input logic [1:0] o,
                          output logic [31:0] yy, output int lat, output logic c,
                          output logic z);
        logic v, r, b;
        @(negedge clk);
        a_in = av;
        sh_in = s[4:0];
        op_in = o;
        iv[sel] = 1'b1;
        @(posedge clk);
        #1;
        iv[sel] = 1'b0;
        lat = 1;
        sample(sel, yy, v, r, b, c, z);
        while (!v && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            sample(sel, yy, v, r, b, c, z);
        end
        total++;
        if (!v || b !== 1'b1 || r !== 1'b0) begin
            bad++;
            $display("FAIL done_state sel=%0d out_valid=%b busy=%b in_ready=%b want 1/1/0",
                     sel, v, b, r);
        end
    endtask

    task automatic retire(input int sel);
        logic [31:0] yy;
        logic v, r, b, c, z;
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        sample(sel, yy, v, r, b, c, z);
        total++;
        if (v !== 1'b0 || r !== 1'b1 || b !== 1'b0) begin
            bad++;
            $display("FAIL retire sel=%0d out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     sel, v, r, b);
        end
    endtask

    task automatic check_op(input string name, input int sel, input logic [31:0] av,
                            input int s, input logic [1:0] o);
        logic [31:0] yy;
        int lat, elat;
        logic c, z;
        longint unsigned ey;
        bit ec;
        model(wid(sel), {32'd0, av}, s, int'(o), ey, ec);
        elat = (s + stp(sel) - 1) / stp(sel) + 1;
        run_op(sel, av, s, o, yy, lat, c, z);
        total++;
        if (yy !== ey[31:0]) begin
            bad++;
            $display("FAIL %s_y sel=%0d a=%h s=%0d op=%0d got=%h want=%h",
                     name, sel, av, s, o, yy, ey[31:0]);
        end
        total++;
        if (lat != elat) begin
            bad++;
            $display("FAIL %s_latency sel=%0d s=%0d got=%0d want=%0d", name, sel, s, lat, elat);
        end
`ifdef SHIFT_FLAGS_EN
        total++;
        if (c !== ec || z !== (ey == 64'd0)) begin
            bad++;
            $display("FAIL %s_flags sel=%0d a=%h s=%0d op=%0d carry=%b zero=%b want %b %b",
                     name, sel, av, s, o, c, z, ec, (ey == 64'd0));
        end
`endif
        retire(sel);
    endtask

    task automatic check_idle_reset(input string name);
        logic [31:0] yy;
        logic v, r, b, c, z;
        for (int sel = 0; sel < 3; sel++) begin
            sample(sel, yy, v, r, b, c, z);
            total++;
            if (yy !== 32'd0 || v !== 1'b0 || b !== 1'b0 || r !== 1'b1 || c !== 1'b0 ||
                z !== 1'b0) begin
                bad++;
                $display("FAIL %s sel=%0d y=%h ov=%b busy=%b ir=%b c=%b z=%b want 0/0/0/1/0/0",
                         name, sel, yy, v, b, r, c, z);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_idle_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] yy;
        int lat;
        logic c, z;
        check_op("sll4", 0, 32'h96, 4, 2'b00);
        check_op("sra2", 0, 32'h96, 2, 2'b10);
        check_op("rol5_step4", 1, 32'h96, 5, 2'b11);
        check_op("srl0", 0, 32'h96, 0, 2'b01);
        // Absolute anchors for the first vector, independent of the model.
        run_op(0, 32'h96, 4, 2'b00, yy, lat, c, z);
        total++;
        if (yy !== 32'h60 || lat != 5) begin
            bad++;
            $display("FAIL anchor_sll4 y=%h lat=%0d want 60 5", yy, lat);
        end
        retire(0);
        check_op("sra_full", 2, 32'h8000_0001, 31, 2'b10);
        check_op("rol_full", 1, 32'h81, 7, 2'b11);
    endtask

    task automatic test_random();
        logic [31:0] av;
        int s;
        logic [1:0] o;
        for (int sel = 0; sel < 3; sel++) begin
            for (int i = 0; i < 30; i++) begin
                av = $urandom();
                if (wid(sel) == 8) av = av & 32'hff;
                s = $urandom_range(wid(sel) - 1, 0);
                o = 2'($urandom_range(3, 0));
                check_op("rand", sel, av, s, o);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] yy, held;
        int lat;
        logic v, r, b, c, z;
        run_op(0, 32'h96, 1, 2'b00, held, lat, c, z);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iv[0] = (i % 2 == 0);
            a_in = 32'h01;
            sh_in = 5'd0;
            op_in = 2'b01;
            @(posedge clk);
            #1;
            sample(0, yy, v, r, b, c, z);
            total++;
            if (yy !== 32'h2c || v !== 1'b1 || r !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d y=%h ov=%b ir=%b want 2c/1/0", i, yy, v, r);
            end
        end
        @(negedge clk);
        iv[0] = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        sample(0, yy, v, r, b, c, z);
        total++;
        if (v !== 1'b0 || r !== 1'b1 || yy !== 32'h2c) begin
            bad++;
            $display("FAIL bp_release ov=%b ir=%b y=%h want 0/1/2c", v, r, yy);
        end
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        sample(0, yy, v, r, b, c, z);
        total++;
        if (v !== 1'b1 || yy !== 32'h01 || b !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept ov=%b y=%h busy=%b want 1/01/1", v, yy, b);
        end
        retire(0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] yy;
        int lat;
        logic v, r, b, c, z;
        @(negedge clk);
        a_in = $urandom() | 32'h1;
        sh_in = 5'd20;
        op_in = 2'b00;
        iv[2] = 1'b1;
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        sample(2, yy, v, r, b, c, z);
        total++;
        if (b !== 1'b1 || v !== 1'b0) begin
            bad++;
            $display("FAIL mid_shift busy=%b ov=%b want 1/0", b, v);
        end
        rst_n = 1'b0;
        #1;
        check_idle_reset("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2, 32'h1, 31, 2'b00, yy, lat, c, z);
        total++;
        if (yy !== 32'h8000_0000 || lat != 32) begin
            bad++;
            $display("FAIL after_reset y=%h lat=%0d want 80000000 32", yy, lat);
        end
        retire(2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
